// File: rtl/serial_frame_ctrl_if.sv
// Handshake/bus bundle between the frame controller, the external shift
// register and the word consumer.
interface serial_frame_ctrl_if #(
    parameter int WIDTH = 5
);
    logic             serial_in;
    logic [WIDTH-1:0] sr_data;
    logic             shift_en;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic             data_ack;
    logic             parity_err;
    logic             frame_err;
    logic             overrun;
    logic             busy;

    modport slave (
        input  serial_in, sr_data, data_ack,
        output shift_en, data_out, data_valid, parity_err, frame_err, overrun, busy
    );

    modport master (
        output serial_in, sr_data, data_ack,
        input  shift_en, data_out, data_valid, parity_err, frame_err, overrun, busy
    );
endinterface

// File: rtl/serial_frame_ctrl.sv
// Start-bit detect / shift-enable sequencer for an external serial-in shift
// register, with parity and stop checks and a valid/ack output handshake.
module serial_frame_ctrl #(
    parameter int WIDTH      = 5,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    serial_frame_ctrl_if.slave   bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, PARITY, STOP} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             perr_q;
    logic             shift_en;
    logic             busy;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic             parity_err;
    logic             frame_err;
    logic             overrun;
    logic             can_commit;

    // A finishing frame may land if the slot is free or is being freed on this edge.
    assign can_commit = !data_valid || bus.data_ack;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            perr_q     <= 1'b0;
            shift_en   <= 1'b0;
            busy       <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!bus.serial_in) begin
                        state    <= SHIFT;
                        cnt      <= '0;
                        shift_en <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (cnt == CW'(WIDTH-1)) begin
                        shift_en <= 1'b0;
                        state    <= (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PARITY: begin
                    perr_q <= ((^bus.sr_data) ^ bus.serial_in) != (PARITY_ODD != 0);
                    state  <= STOP;
                end
                STOP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase

            // Output slot: commit on the stop edge, otherwise plain ack handling.
            if (state == STOP) begin
                if (can_commit) begin
                    data_out   <= bus.sr_data;
                    parity_err <= (PARITY_EN != 0) ? perr_q : 1'b0;
                    frame_err  <= !bus.serial_in;
                    data_valid <= 1'b1;
                    overrun    <= 1'b0;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (data_valid && bus.data_ack) begin
                data_valid <= 1'b0;
                overrun    <= 1'b0;
            end
        end
    end

    assign bus.shift_en   = shift_en;
    assign bus.busy       = busy;
    assign bus.data_out   = data_out;
    assign bus.data_valid = data_valid;
    assign bus.parity_err = parity_err;
    assign bus.frame_err  = frame_err;
    assign bus.overrun    = overrun;
endmodule

// File: tb/tb_serial_frame_ctrl.sv
// Scoreboard bench: instance a (even parity) and instance b (no parity bit,
// odd setting ignored), each driving its own model shift register.
module tb_serial_frame_ctrl;
    localparam int W = 5;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    serial_frame_ctrl_if #(.WIDTH(W)) ifa ();
    serial_frame_ctrl_if #(.WIDTH(W)) ifb ();

    serial_frame_ctrl #(.WIDTH(W), .PARITY_EN(1), .PARITY_ODD(0)) dut_a (
        .clk(clk), .reset_n(reset_n), .bus(ifa.slave));
    serial_frame_ctrl #(.WIDTH(W), .PARITY_EN(0), .PARITY_ODD(1)) dut_b (
        .clk(clk), .reset_n(reset_n), .bus(ifb.slave));

    // External shift registers, not reset by the controller
    logic [W-1:0] sra = '0, srb = '0;
    always @(posedge clk) begin
        if (ifa.shift_en) sra <= {sra[W-2:0], ifa.serial_in};
        if (ifb.shift_en) srb <= {srb[W-2:0], ifb.serial_in};
    end
    assign ifa.sr_data = sra;
    assign ifb.sr_data = srb;

    typedef struct packed {
        logic [W-1:0] d;
        logic         pe;
        logic         fe;
    } exp_t;

    exp_t qa[$], qb[$];
    exp_t ea, eb;
    int tests = 0, fails = 0;
    bit mvalid[2], movr[2];
    logic [W-1:0] mdata[2];
    int sh_cnt[2];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // {data_out, data_valid, parity_err, frame_err, overrun, busy, shift_en}
    function automatic logic [W+5:0] outs(input int w);
        if (w == 0)
            return {ifa.data_out, ifa.data_valid, ifa.parity_err, ifa.frame_err,
                    ifa.overrun, ifa.busy, ifa.shift_en};
        return {ifb.data_out, ifb.data_valid, ifb.parity_err, ifb.frame_err,
                ifb.overrun, ifb.busy, ifb.shift_en};
    endfunction

    // Monitors: a new word is presented when valid rises, or when valid stays
    // high across an edge on which ack was asserted.
    logic pva = 0, paa = 0, pvb = 0, pab = 0;
    always @(negedge clk) begin
        if (ifa.shift_en) sh_cnt[0]++;
        if (!reset_n) begin
            pva = 0; paa = 0;
        end else begin
            if (ifa.data_valid && (!pva || paa)) begin
                if (qa.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL a_unexpected_word: got %0h expected none", ifa.data_out);
                end else begin
                    ea = qa.pop_front();
                    check("a_data", ifa.data_out, ea.d);
                    check("a_parity_err", ifa.parity_err, ea.pe);
                    check("a_frame_err", ifa.frame_err, ea.fe);
                end
            end
            pva = ifa.data_valid; paa = ifa.data_ack;
        end
    end

    always @(negedge clk) begin
        if (ifb.shift_en) sh_cnt[1]++;
        if (!reset_n) begin
            pvb = 0; pab = 0;
        end else begin
            if (ifb.data_valid && (!pvb || pab)) begin
                if (qb.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL b_unexpected_word: got %0h expected none", ifb.data_out);
                end else begin
                    eb = qb.pop_front();
                    check("b_data", ifb.data_out, eb.d);
                    check("b_parity_err", ifb.parity_err, eb.pe);
                    check("b_frame_err", ifb.frame_err, eb.fe);
                end
            end
            pvb = ifb.data_valid; pab = ifb.data_ack;
        end
    end

    task automatic set_line(input int w, input bit b);
        if (w == 0) ifa.serial_in = b; else ifb.serial_in = b;
    endtask

    task automatic set_ack(input int w, input bit b);
        if (w == 0) ifa.data_ack = b; else ifb.data_ack = b;
    endtask

    task automatic drive(input int w, input bit b);
        set_line(w, b);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int w, input int n);
        logic [W+5:0] o;
        set_line(w, 1'b1);
        repeat (n) begin
            @(posedge clk); #1;
            o = outs(w);
            check("idle_busy_shift", o[1:0], 2'b00);
        end
    endtask

    task automatic do_ack(input int w);
        logic [W+5:0] o;
        set_line(w, 1'b1);
        set_ack(w, 1'b1);
        @(posedge clk); #1;
        set_ack(w, 1'b0);
        if (mvalid[w]) begin mvalid[w] = 0; movr[w] = 0; end
        o = outs(w);
        check("ack_valid", o[5], 1'b0);
        check("ack_overrun", o[2], movr[w]);
    endtask

    // Frame: start, data MSB-first (first bit ends in sr_data[W-1]), parity (a only), stop.
    task automatic send_frame(input int w, input logic [W-1:0] d, input bit p,
                              input bit stop, input bit ack_stop);
        int c0;
        exp_t e;
        logic [W+5:0] o;
        c0 = sh_cnt[w];
        drive(w, 1'b0);
        for (int i = W - 1; i >= 0; i--) drive(w, d[i]);
        if (w == 0) drive(w, p);
        o = outs(w);
        check("valid_before_stop", o[5], mvalid[w]);
        set_ack(w, ack_stop);
        drive(w, stop);
        set_ack(w, 1'b0);
        e.d  = d;
        e.pe = (w == 0) ? ((($countones(d) + int'(p)) % 2) != 0) : 1'b0;
        e.fe = !stop;
        if (!mvalid[w] || ack_stop) begin
            if (w == 0) qa.push_back(e); else qb.push_back(e);
            mvalid[w] = 1; movr[w] = 0; mdata[w] = d;
        end else begin
            movr[w] = 1;
        end
        o = outs(w);
        check("valid_after_stop", o[5], 1'b1);
        check("data_out_held", o[W+5:6], mdata[w]);
        check("overrun", o[2], movr[w]);
        check("busy_after_stop", o[1], 1'b0);
        check("shift_cycles", sh_cnt[w] - c0, W);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        check("rst_outs_a", outs(0), '0);
        check("rst_outs_b", outs(1), '0);
        for (int w = 0; w < 2; w++) begin mvalid[w] = 0; movr[w] = 0; mdata[w] = '0; end
        qa.delete(); qb.delete();
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    logic [W-1:0] rd;
    bit rp, rs, ra;

    initial begin
        ifa.serial_in = 1'b1; ifa.data_ack = 1'b0;
        ifb.serial_in = 1'b1; ifb.data_ack = 1'b0;
        @(posedge clk); #1;
        do_reset();
        idle(0, 2);

        // Clean frame, parity error, recovery
        send_frame(0, 5'b10110, 1'b1, 1'b1, 1'b0);
        do_ack(0);
        send_frame(0, 5'b10110, 1'b0, 1'b1, 1'b0);
        do_ack(0);
        send_frame(0, 5'b10110, 1'b1, 1'b1, 1'b0);
        do_ack(0);

        // Framing error, line held low: next edge is a fresh start bit
        send_frame(0, 5'b01101, 1'b1, 1'b0, 1'b0);
        send_frame(0, 5'b10011, 1'b1, 1'b1, 1'b1);
        do_ack(0);

        // Overrun, then the same pair with ack on the second stop edge
        send_frame(0, 5'b00001, 1'b1, 1'b1, 1'b0);
        send_frame(0, 5'b11111, 1'b1, 1'b1, 1'b0);
        do_ack(0);
        send_frame(0, 5'b00001, 1'b1, 1'b1, 1'b0);
        send_frame(0, 5'b11111, 1'b1, 1'b1, 1'b1);

        // Reset after data bit 2, then a clean frame
        drive(0, 1'b0); drive(0, 1'b1); drive(0, 1'b1); drive(0, 1'b0);
        set_line(0, 1'b1);
        do_reset();
        idle(0, 2);
        send_frame(0, 5'b01010, 1'b0, 1'b1, 1'b0);
        do_ack(0);

        // No-parity build
        idle(1, 2);
        send_frame(1, 5'b11100, 1'b0, 1'b1, 1'b0);
        idle(1, 20);
        do_ack(1);

        // Randomized traffic on the parity build
        for (int k = 0; k < 40; k++) begin
            rd = W'($urandom);
            rp = (^rd) ^ ($urandom_range(0, 3) == 0);
            rs = ($urandom_range(0, 4) != 0);
            ra = ($urandom_range(0, 3) == 0);
            if (mvalid[0] && ($urandom_range(0, 1) == 1)) do_ack(0);
            send_frame(0, rd, rp, rs, ra);
            idle(0, $urandom_range(0, 2));
        end
        do_ack(0);
        idle(0, 2);

        check("a_queue_drained", qa.size(), 0);
        check("b_queue_drained", qb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/serial_frame_ctrl.md
# serial_frame_ctrl

Sequencing controller for the 5-bit serial-in shift register. Watches the serial line for a start bit and enables the register for exactly WIDTH shift cycles. It then checks an optional parity bit and the stop bit, and presents the captured word on a valid/ack handshake with error and overrun flags. The register's clock stays free-running: the controller qualifies shifting with an enable instead of gating the clock.

## Interface
- WIDTH, 5: data bits per frame; must match the shift register length (≥2).
- PARITY_EN, 1: 1 = frame carries a parity bit after the data bits; 0 = no parity bit.
- PARITY_ODD, 0: 0 = even parity, 1 = odd parity (ignored when PARITY_EN=0).

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- serial_in  in  1  serial line, one bit per clk; idles high.
- sr_data  in  WIDTH  parallel output of the shift register.
- shift_en  out  WIDTH?no: 1  register shift enable; when high, the register shifts in serial_in on that edge.
- data_out  out  WIDTH  captured word.
- data_valid  out  1  data_out holds an unacknowledged word.
- data_ack  in  1  consumer acknowledge.
- parity_err  out  1  parity mismatch for the word in data_out.
- frame_err  out  1  stop bit sampled low for the word in data_out.
- overrun  out  1  a completed frame was dropped because data_valid was still high.
- busy  out  1  high whenever state ≠ IDLE.

## Operation
- Shift register contract:
  - When shift_en is high, the register does sr_data <= {sr_data[WIDTH-2:0], serial_in}.
  - The first data bit received ends up in sr_data[WIDTH-1].
  - data_out = sr_data, with no reordering.
- FSM states:
  - IDLE:
    - busy=0, shift_en=0.
    - serial_in=0 sampled → SHIFT, bit counter cleared to 0.
    - serial_in=1 → stay in IDLE.
  - SHIFT:
    - shift_en=1 (Moore output).
    - Counter increments each cycle.
    - At counter=WIDTH-1 → PARITY if PARITY_EN=1, else STOP.
    - Counter width is ceil(log2(WIDTH)); it never wraps within a frame.
  - PARITY:
    - shift_en=0.
    - Samples serial_in as parity bit p; perr_q <= (^sr_data ^ p) ≠ PARITY_ODD.
    - → STOP.
  - STOP:
    - shift_en=0.
    - Samples serial_in; ferr = !serial_in.
    - Commits the word (see below), then → IDLE unconditionally, including when ferr=1.
- Commit on the STOP edge:
  - If data_valid=0, or data_ack=1 on that same edge:
    - data_out<=sr_data, parity_err<=perr_q (0 when PARITY_EN=0), frame_err<=ferr, data_valid<=1.
  - Otherwise the frame is dropped: data_out and the error flags are unchanged, overrun<=1.
- Handshake:
  - data_ack=1 with data_valid=1 on an edge, and no commit on that edge → data_valid<=0, overrun<=0.
  - The error flags are left unchanged.
  - data_ack while data_valid=0 is ignored.
- overrun is sticky until an ack is accepted.
- Reset (asynchronous, any state including mid-frame):
  - State → IDLE, counter=0.
  - data_out, data_valid, parity_err, frame_err, overrun, perr_q all cleared to 0.
  - shift_en=0 and busy=0 immediately.

## Timing
- Edge E0 samples the start bit.
- Data bit i is shifted on edge E(1+i), i=0..WIDTH-1; shift_en is high for exactly WIDTH consecutive cycles.
- Parity bit is sampled at E(WIDTH+1) when PARITY_EN=1.
- Stop bit is sampled at E(WIDTH+1+PARITY_EN); data_valid rises after that edge.
- For WIDTH=5 with parity: stop at E7, data_valid high from E7.
- Back-to-back frames: IDLE lasts ≥1 cycle after STOP, so the earliest next start is sampled one edge after the stop edge. The minimum frame period is WIDTH+2+PARITY_EN cycles.
- serial_in during SHIFT is never interpreted as a start bit.
- busy rises after E0 and falls after the stop edge.

## Test plan
- Clean frame, WIDTH=5, even parity:
  - Stimulus: start 0, data 1,0,1,1,0, parity 1, stop 1.
  - Required: data_out=5'b10110, data_valid=1 after E7, parity_err=0, frame_err=0, exactly 5 shift_en cycles.
- Parity error:
  - Stimulus: same frame but parity 0.
  - Required: data_out=5'b10110, parity_err=1, data_valid=1.
  - Stimulus: a correct frame after ack.
  - Required: parity_err=0.
- Framing error:
  - Stimulus: stop bit 0.
  - Required: frame_err=1, data_valid=1, FSM back in IDLE next cycle.
  - Stimulus: the line stays low.
  - Required: the next edge is taken as a new start bit.
- Overrun and simultaneous ack:
  - Stimulus: two back-to-back frames 5'b00001 and 5'b11111, never acked.
  - Required: data_out=5'b00001, overrun=1.
  - Stimulus: repeat with data_ack=1 on the second stop edge.
  - Required: data_out=5'b11111, data_valid=1, overrun=0.
- Reset mid-frame:
  - Stimulus: reset_n low after data bit 2.
  - Required: all outputs 0 immediately.
  - Stimulus: reset_n released, then a full frame 5'b01010.
  - Required: data_out=5'b01010 with no residue from the aborted frame.
- PARITY_EN=0, PARITY_ODD=1 build:
  - Stimulus: frame 5'b11100.
  - Required: valid after E6, parity_err=0.
  - Stimulus: idle line held high 20 cycles.
  - Required: busy=0 and shift_en=0 throughout.
